bmem_responder: RTL and testbench
=================================

# bmem_responder

Synthesizable responder for the burst memory (bmem) protocol that the mp4 CPU drives from its cache-line side. It backs a small line-organised RAM, serves 4-beat 64-bit read and write bursts with a programmable first-beat latency, and flags protocol violations on a sticky error output. It replaces the behavioural burst memory model for standalone or FPGA bring-up, and can sit behind `mp4` in a self-checking loopback bench.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 64, beat width.
- `BURST_LEN`, 4, beats per line; line is 32 bytes, offset bits are [4:0].
- `DEPTH_LINES`, 256, lines of storage; valid range is `0 .. DEPTH_LINES*32-1`.
- `LATENCY`, 3, cycles from request capture to first `bmem_resp`; minimum 1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bmem_address` in ADDR_WIDTH: line address; must be held for the whole burst.
- `bmem_read` in 1: read request; held until the last beat.
- `bmem_write` in 1: write request; held until the last beat.
- `bmem_wdata` in DATA_WIDTH: write beat. The host advances it after each cycle in which `bmem_resp` is high.
- `bmem_rdata` out DATA_WIDTH: read beat; valid only while `bmem_resp` is high.
- `bmem_resp` out 1: beat strobe.
- `error` out 1: sticky OR of `err_cause`.
- `err_cause` out 4: sticky per-bit causes.
  - [0] read and write asserted together.
  - [1] misaligned address (`addr[4:0] != 0`).
  - [2] address out of range.
  - [3] request dropped or address changed mid-burst.
- `rd_bursts` out 32: completed read bursts.
- `wr_bursts` out 32: completed write bursts.

## Operation
- **FSM states:** IDLE, WAIT, RBURST, WBURST, TURN.
- **IDLE:**
  - `read` or `write` high at an edge: capture address and direction, load latency counter with `LATENCY-1`, go to WAIT.
  - If read and write are both high: set `err_cause[0]` and treat the request as a read.
  - Misaligned address: set `err_cause[1]`; the burst proceeds with the offset bits ignored.
- **WAIT:**
  - Decrement the counter.
  - At 0, go to RBURST or WBURST with beat index 0.
- **RBURST:**
  - `bmem_resp=1`; `bmem_rdata` = `mem[line][beat]`.
  - The beat index increments each cycle.
  - After beat `BURST_LEN-1`, go to TURN.
- **WBURST:**
  - `bmem_resp=1`; `mem[line][beat] <= bmem_wdata` at each edge.
  - Same index rules as RBURST; exits to TURN.
- **TURN:**
  - One cycle; requests are ignored.
  - Increment `rd_bursts` or `wr_bursts`, then go to IDLE.
- **Out of range:** set `err_cause[2]`. The burst still runs full length, reads return 0, and writes are dropped.
- **Mid-burst check:** in WAIT, RBURST and WBURST, if the request deasserts or the address differs from the captured address, set `err_cause[3]`. The burst still completes (the responder never aborts).
- **Storage:** line index = `addr[5 +: $clog2(DEPTH_LINES)]`.
- **Counters:** wrap modulo 2^32.

## Timing
- **Reset values:** `bmem_resp=0`, `bmem_rdata=0`, `error=0`, `err_cause=0`, both counters 0, state IDLE.
- **Reset and memory:** RAM contents are not reset.
- **Reset mid-burst:** the state returns to IDLE immediately. Beats already written persist and the remaining beats are never written. No counter increment.
- **Latency:** request sampled at edge T; `bmem_resp` is high in cycles T+LATENCY .. T+LATENCY+3.
- **Read data:** `bmem_rdata` is registered; beat k is driven during cycle T+LATENCY+k.
- **Turnaround:** the earliest next request capture is at the edge ending the TURN cycle, i.e. 2 cycles after the last resp edge.
- **Write capture:** occurs at the same edge that ends a resp cycle.
- **Back-to-back requests:** a request held high through TURN is captured as a new burst. The host is required to drop it; this is not an error.

## Structure
- **`bmem_pkg`:**
  - `bmem_state_e` enum.
  - `LINE_BYTES=32` and `OFFSET_BITS=5`.
  - The `err_cause` bit-index localparams.
- **Sub-module `bmem_line_ram`:**
  - Synchronous-read beat RAM, `DEPTH_LINES*BURST_LEN` x `DATA_WIDTH`.
  - Indexed by `{line, beat}`, one read port and one write port.
  - The responder owns the FSM, checks and counters.

## Test plan
- **Write then read:**
  - Stimulus: write burst to 0x40 with beats 0x1111..,0x2222..,0x3333..,0x4444.., then a read of 0x40.
  - Required: resp is high exactly 4 cycles starting LATENCY after capture; rdata matches in order; `wr_bursts=1`, `rd_bursts=1`; `error=0`.
- **Latency sweep:** `LATENCY` 1 and 5 → first resp exactly 1 or 5 cycles after the capture edge; there is a 1-cycle TURN gap before the next burst's WAIT.
- **Simultaneous read and write:**
  - Stimulus: read=write=1 at 0x80.
  - Required: `err_cause=4'b0001`; a read burst of stored data is served; `error` stays high until `rst_n` falls.
- **Misaligned and out-of-range addresses:**
  - Read at 0x44 → `err_cause[1]`; the line 0x40 data is returned.
  - Read at `DEPTH_LINES*32` → `err_cause[2]`; four zero beats are returned.
- **Address changed mid-burst:** the address is changed during beat 1 of a read → `err_cause[3]`; the burst still delivers 4 beats from the original line.
- **Reset mid-write:**
  - Stimulus: `rst_n` low after beat 1 of a write to 0xC0, then release, then read 0xC0.
  - Required: beats 0-1 are new data and beats 2-3 are old; counters and `error` are 0 after reset.

Source files
------------

// File: rtl/bmem_pkg.sv
// bmem_pkg
// Shared definitions for the burst-memory responder slice.
//   bmem_state_e : responder FSM states
//   LINE_BYTES   : bytes per cache line (4 beats of 64 bits)
//   OFFSET_BITS  : byte-offset bits inside a line
//   ERR_*        : bit positions inside err_cause
package bmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        TURN
    } bmem_state_e;

    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = 5;

    localparam int ERR_BITS     = 4;
    localparam int ERR_RW_BOTH  = 0;
    localparam int ERR_MISALIGN = 1;
    localparam int ERR_RANGE    = 2;
    localparam int ERR_PROTOCOL = 3;

endpackage

// File: rtl/bmem_line_ram.sv
// bmem_line_ram
// Beat-organised storage behind the responder: one word per beat, addressed
// as {line, beat}. One synchronous read port, one write port. Contents are
// never reset.
//   clk     : clock, rising edge
//   rd_en   : load rd_data from mem[rd_addr] at the next edge
//   rd_addr : read word address
//   rd_data : registered read data
//   wr_en   : write wr_data into mem[wr_addr] at the next edge
//   wr_addr : write word address
//   wr_data : write data
module bmem_line_ram
    import bmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Plain RAM template with no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bmem_responder.sv
// bmem_responder
// Burst-memory responder: accepts 4-beat line reads and writes from the
// host, waits LATENCY cycles, then strobes bmem_resp once per beat. Protocol
// violations are recorded in sticky err_cause bits; bursts are never aborted.
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   bmem_address : line address, held by the host for the whole burst
//   bmem_read    : read request, held until the last beat
//   bmem_write   : write request, held until the last beat
//   bmem_wdata   : write beat, advanced by the host after each resp cycle
//   bmem_rdata   : read beat, valid while bmem_resp is high
//   bmem_resp    : beat strobe
//   error        : OR of err_cause
//   err_cause    : sticky causes (rw both, misaligned, out of range, protocol)
//   rd_bursts    : completed read bursts
//   wr_bursts    : completed write bursts
module bmem_responder
    import bmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_LEN   = 4,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] bmem_address,
    input  logic                  bmem_read,
    input  logic                  bmem_write,
    input  logic [DATA_WIDTH-1:0] bmem_wdata,
    output logic [DATA_WIDTH-1:0] bmem_rdata,
    output logic                  bmem_resp,
    output logic                  error,
    output logic [ERR_BITS-1:0]   err_cause,
    output logic [31:0]           rd_bursts,
    output logic [31:0]           wr_bursts
);

    localparam int LINE_BITS = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int BEAT_BITS = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int RAM_BITS  = LINE_BITS + BEAT_BITS;

    localparam logic [ADDR_WIDTH:0]  ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH_LINES * LINE_BYTES);
    localparam logic [CNT_BITS-1:0]  CNT_LOAD   = CNT_BITS'(LATENCY - 1);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT  = BEAT_BITS'(BURST_LEN - 1);

    bmem_state_e state, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  dir_read;
    logic                  in_range_reg;
    logic [CNT_BITS-1:0]   cnt, cnt_next;
    logic [BEAT_BITS-1:0]  beat, beat_next;
    logic [ERR_BITS-1:0]   err_set;
    logic [LINE_BITS-1:0]  line;

    logic request;
    logic capture;
    logic addr_in_range;
    logic misaligned;
    logic req_dropped;
    logic in_burst;

    logic                  ram_rd_en;
    logic                  ram_wr_en;
    logic [RAM_BITS-1:0]   ram_rd_addr;
    logic [RAM_BITS-1:0]   ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign request       = bmem_read | bmem_write;
    // A request held through TURN is taken at the edge that ends TURN, which
    // gives the one-cycle turnaround gap between back-to-back bursts.
    assign capture       = request && ((state == IDLE) || (state == TURN));
    assign addr_in_range = ({1'b0, bmem_address} < ADDR_LIMIT);
    assign misaligned    = (bmem_address[OFFSET_BITS-1:0] != '0);
    assign req_dropped   = dir_read ? !bmem_read : !bmem_write;
    assign in_burst      = (state == WAIT) || (state == RBURST) || (state == WBURST);
    assign line          = addr_reg[OFFSET_BITS +: LINE_BITS];

    // State register; reset drops any burst in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, latency/beat counters and RAM read strobe. The RAM read is
    // issued one cycle ahead (last WAIT cycle, then every beat but the last)
    // so the registered read data lines up with each resp cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        beat_next  = beat;
        ram_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = dir_read ? RBURST : WBURST;
                    beat_next  = '0;
                    ram_rd_en  = dir_read;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RBURST: begin
                beat_next = beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    state_next = TURN;
                end else begin
                    ram_rd_en = 1'b1;
                end
            end
            WBURST: begin
                beat_next = beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    state_next = TURN;
                end
            end
            TURN: begin
                if (capture) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // New error causes seen this cycle: request checks at capture, and the
    // hold checks while a burst is outstanding.
    always_comb begin
        err_set = '0;
        if (capture) begin
            err_set[ERR_RW_BOTH]  = bmem_read & bmem_write;
            err_set[ERR_MISALIGN] = misaligned;
            err_set[ERR_RANGE]    = !addr_in_range;
        end
        if (in_burst && (req_dropped || (bmem_address != addr_reg))) begin
            err_set[ERR_PROTOCOL] = 1'b1;
        end
    end

    // Burst context captured with the request. Read wins when both
    // directions are requested together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            dir_read     <= 1'b0;
            in_range_reg <= 1'b0;
            cnt          <= '0;
            beat         <= '0;
        end else begin
            cnt  <= cnt_next;
            beat <= beat_next;
            if (capture) begin
                addr_reg     <= bmem_address;
                dir_read     <= bmem_read;
                in_range_reg <= addr_in_range;
            end
        end
    end

    // Sticky error causes and burst counters; a burst only counts once it
    // has reached TURN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cause <= '0;
            rd_bursts <= '0;
            wr_bursts <= '0;
        end else begin
            err_cause <= err_cause | err_set;
            if (state == TURN) begin
                if (dir_read) begin
                    rd_bursts <= rd_bursts + 32'd1;
                end else begin
                    wr_bursts <= wr_bursts + 32'd1;
                end
            end
        end
    end

    assign ram_rd_addr = {line, beat_next};
    assign ram_wr_addr = {line, beat};
    // Out-of-range writes are dropped; the burst still runs its full length.
    assign ram_wr_en   = (state == WBURST) && in_range_reg;

    bmem_line_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_LINES * BURST_LEN),
        .ADDR_BITS   (RAM_BITS)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (bmem_wdata)
    );

    assign bmem_resp  = (state == RBURST) || (state == WBURST);
    // Gating keeps rdata at zero outside read beats and for out-of-range
    // reads, whatever the RAM output register holds.
    assign bmem_rdata = ((state == RBURST) && in_range_reg) ? ram_rd_data : '0;
    assign error      = |err_cause;

endmodule

// File: tb/tb_bmem_responder.sv
// tb_bmem_responder
// Directed bench for bmem_responder. Instance 0 uses LATENCY=3 and carries
// the table of bursts; instances 1 and 2 use LATENCY=1 and 5 for the
// back-to-back timing sequence. Idle instances are held in reset so the
// shared request lines only reach the instance under test.
module tb_bmem_responder;

    logic        clk;
    logic [31:0] bmem_address;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;

    logic        rstn_a  [3];
    logic        resp_a  [3];
    logic [63:0] rdata_a [3];
    logic        error_a [3];
    logic [3:0]  cause_a [3];
    logic [31:0] rdc_a   [3];
    logic [31:0] wrc_a   [3];

    int compared;
    int failed;

    typedef struct packed {
        logic            rd;
        logic            wr;
        logic [31:0]     addr;
        logic [3:0][63:0] beats;
        logic [3:0]      exp_err;
        logic [31:0]     exp_rd;
        logic [31:0]     exp_wr;
    } vec_t;

    vec_t vecs [9];

    bmem_responder #(.LATENCY(3)) dut0 (
        .clk(clk), .rst_n(rstn_a[0]), .bmem_address(bmem_address),
        .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_rdata(rdata_a[0]), .bmem_resp(resp_a[0]), .error(error_a[0]),
        .err_cause(cause_a[0]), .rd_bursts(rdc_a[0]), .wr_bursts(wrc_a[0])
    );

    bmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rstn_a[1]), .bmem_address(bmem_address),
        .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_rdata(rdata_a[1]), .bmem_resp(resp_a[1]), .error(error_a[1]),
        .err_cause(cause_a[1]), .rd_bursts(rdc_a[1]), .wr_bursts(wrc_a[1])
    );

    bmem_responder #(.LATENCY(5)) dut2 (
        .clk(clk), .rst_n(rstn_a[2]), .bmem_address(bmem_address),
        .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_rdata(rdata_a[2]), .bmem_resp(resp_a[2]), .error(error_a[2]),
        .err_cause(cause_a[2]), .rd_bursts(rdc_a[2]), .wr_bursts(wrc_a[2])
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [63:0] b0, input logic [63:0] b1,
                                   input logic [63:0] b2, input logic [63:0] b3,
                                   input logic [3:0] err, input int nrd, input int nwr);
        vec_t v;
        v.rd       = rd;
        v.wr       = wr;
        v.addr     = addr;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        v.exp_err  = err;
        v.exp_rd   = 32'(nrd);
        v.exp_wr   = 32'(nwr);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Runs one burst on instance sel. Request lines change on the falling
    // edge; k counts cycles after the capture edge. The request is dropped
    // in the first quiet cycle after the beats (TURN), and the task returns
    // one cycle later so the burst counters have settled. chg_beat >= 0
    // perturbs the address during that beat.
    task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [3:0][63:0] beats,
                                 input int chg_beat, output int lat, output int nresp,
                                 output logic [3:0][63:0] got);
        bit done;
        lat   = -1;
        nresp = 0;
        got   = '0;
        done  = 1'b0;
        @(negedge clk);
        bmem_address = addr;
        bmem_read    = rd;
        bmem_write   = wr;
        bmem_wdata   = beats[0];
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (resp_a[sel]) begin
                if (lat < 0) lat = k;
                if (nresp < 4) begin
                    got[nresp] = rdata_a[sel];
                    bmem_wdata = beats[nresp];
                end
                if (nresp == chg_beat) bmem_address = addr ^ 32'h0000_0100;
                nresp++;
            end else if (nresp > 0) begin
                bmem_read  = 1'b0;
                bmem_write = 1'b0;
                done       = 1'b1;
            end
        end
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_address = addr;
        @(negedge clk);
    endtask

    // Holds a read request across two bursts and measures first latency,
    // both beat runs and the quiet gap between them (TURN plus WAIT).
    task automatic measureBackToBack(input int sel, input int exp_lat);
        int phase;
        int first_lat;
        int run1;
        int gap;
        int run2;
        phase     = 0;
        first_lat = -1;
        run1      = 0;
        gap       = 0;
        run2      = 0;
        @(negedge clk);
        bmem_address = 32'h0000_0040;
        bmem_read    = 1'b1;
        bmem_write   = 1'b0;
        for (int k = 0; k < 60 && phase < 4; k++) begin
            @(negedge clk);
            case (phase)
                0: if (resp_a[sel]) begin first_lat = k; run1 = 1; phase = 1; end
                1: if (resp_a[sel]) run1++; else begin gap = 1; phase = 2; end
                2: if (resp_a[sel]) begin run2 = 1; phase = 3; end else gap++;
                3: if (resp_a[sel]) run2++; else begin bmem_read = 1'b0; phase = 4; end
                default: phase = 4;
            endcase
        end
        bmem_read = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("lat%0d first_latency", exp_lat), 64'(first_lat), 64'(exp_lat));
        checkOutput($sformatf("lat%0d run1_beats", exp_lat), 64'(run1), 64'd4);
        checkOutput($sformatf("lat%0d gap_cycles", exp_lat), 64'(gap), 64'(exp_lat + 1));
        checkOutput($sformatf("lat%0d run2_beats", exp_lat), 64'(run2), 64'd4);
        checkOutput($sformatf("lat%0d rd_bursts", exp_lat), 64'(rdc_a[sel]), 64'd2);
        checkOutput($sformatf("lat%0d error", exp_lat), 64'(error_a[sel]), 64'd0);
    endtask

    // Main sequence: reset state, burst table, then hand-written corners.
    initial begin
        int lat;
        int nresp;
        int seen;
        logic [3:0][63:0] got;
        logic [3:0][63:0] beats;
        logic [3:0][63:0] exp_beats;

        compared     = 0;
        failed       = 0;
        bmem_address = '0;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_wdata   = '0;
        rstn_a[0]    = 1'b0;
        rstn_a[1]    = 1'b0;
        rstn_a[2]    = 1'b0;
        repeat (3) @(negedge clk);
        rstn_a[0] = 1'b1;
        @(negedge clk);

        checkOutput("reset resp",      64'(resp_a[0]),  64'd0);
        checkOutput("reset rdata",     rdata_a[0],      64'd0);
        checkOutput("reset error",     64'(error_a[0]), 64'd0);
        checkOutput("reset err_cause", 64'(cause_a[0]), 64'd0);
        checkOutput("reset rd_bursts", 64'(rdc_a[0]),   64'd0);
        checkOutput("reset wr_bursts", 64'(wrc_a[0]),   64'd0);

        vecs[0] = mkVec(0, 1, 32'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                        64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4'b0000, 0, 1);
        vecs[1] = mkVec(1, 0, 32'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                        64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4'b0000, 1, 1);
        vecs[2] = mkVec(0, 1, 32'h80, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                        64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 4'b0000, 1, 2);
        vecs[3] = mkVec(0, 1, 32'h00, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
                        64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004, 4'b0000, 1, 3);
        vecs[4] = mkVec(1, 1, 32'h80, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                        64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 4'b0001, 2, 3);
        vecs[5] = mkVec(1, 0, 32'h44, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                        64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4'b0011, 3, 3);
        vecs[6] = mkVec(1, 0, 32'h2000, 64'h0, 64'h0, 64'h0, 64'h0, 4'b0111, 4, 3);
        vecs[7] = mkVec(0, 1, 32'h2000, 64'h9999_9999_9999_9999, 64'h9999_9999_9999_999A,
                        64'h9999_9999_9999_999B, 64'h9999_9999_9999_999C, 4'b0111, 4, 4);
        vecs[8] = mkVec(1, 0, 32'h00, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002,
                        64'hA3A3_0000_0000_0003, 64'hA4A4_0000_0000_0004, 4'b0111, 5, 4);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].beats, -1, lat, nresp, got);
            checkOutput($sformatf("v%0d latency", i), 64'(lat), 64'd3);
            checkOutput($sformatf("v%0d resp_beats", i), 64'(nresp), 64'd4);
            if (vecs[i].rd) begin
                for (int b = 0; b < 4; b++) begin
                    checkOutput($sformatf("v%0d rdata[%0d]", i, b), got[b], vecs[i].beats[b]);
                end
            end
            checkOutput($sformatf("v%0d err_cause", i), 64'(cause_a[0]), 64'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d error", i), 64'(error_a[0]), 64'(|vecs[i].exp_err));
            checkOutput($sformatf("v%0d rd_bursts", i), 64'(rdc_a[0]), 64'(vecs[i].exp_rd));
            checkOutput($sformatf("v%0d wr_bursts", i), 64'(wrc_a[0]), 64'(vecs[i].exp_wr));
        end

        // Address moved during beat 1: protocol error, original line served.
        exp_beats[0] = 64'h1111_1111_1111_1111;
        exp_beats[1] = 64'h2222_2222_2222_2222;
        exp_beats[2] = 64'h3333_3333_3333_3333;
        exp_beats[3] = 64'h4444_4444_4444_4444;
        applyStimulus(0, 1'b1, 1'b0, 32'h40, exp_beats, 1, lat, nresp, got);
        checkOutput("addrchg resp_beats", 64'(nresp), 64'd4);
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("addrchg rdata[%0d]", b), got[b], exp_beats[b]);
        end
        checkOutput("addrchg err_cause", 64'(cause_a[0]), 64'b1111);
        checkOutput("addrchg rd_bursts", 64'(rdc_a[0]), 64'd6);

        // Reset in the middle of a write to 0xC0 after two beats have landed.
        beats[0] = 64'hC1C1_C1C1_C1C1_C1C1;
        beats[1] = 64'hC2C2_C2C2_C2C2_C2C2;
        beats[2] = 64'hC3C3_C3C3_C3C3_C3C3;
        beats[3] = 64'hC4C4_C4C4_C4C4_C4C4;
        applyStimulus(0, 1'b0, 1'b1, 32'hC0, beats, -1, lat, nresp, got);
        checkOutput("prewrite wr_bursts", 64'(wrc_a[0]), 64'd5);

        beats[0] = 64'hD1D1_D1D1_D1D1_D1D1;
        beats[1] = 64'hD2D2_D2D2_D2D2_D2D2;
        beats[2] = 64'hD3D3_D3D3_D3D3_D3D3;
        beats[3] = 64'hD4D4_D4D4_D4D4_D4D4;
        seen = 0;
        @(negedge clk);
        bmem_address = 32'hC0;
        bmem_write   = 1'b1;
        bmem_wdata   = beats[0];
        for (int k = 0; k < 20 && seen < 2; k++) begin
            @(negedge clk);
            if (resp_a[0]) begin
                bmem_wdata = beats[seen];
                seen++;
            end
        end
        @(negedge clk);
        checkOutput("midreset beats_before_reset", 64'(seen), 64'd2);
        checkOutput("midreset resp_in_beat2", 64'(resp_a[0]), 64'd1);
        rstn_a[0]  = 1'b0;
        bmem_write = 1'b0;
        #1;
        checkOutput("midreset resp",      64'(resp_a[0]),  64'd0);
        checkOutput("midreset error",     64'(error_a[0]), 64'd0);
        checkOutput("midreset err_cause", 64'(cause_a[0]), 64'd0);
        checkOutput("midreset rd_bursts", 64'(rdc_a[0]),   64'd0);
        checkOutput("midreset wr_bursts", 64'(wrc_a[0]),   64'd0);
        @(negedge clk);
        rstn_a[0] = 1'b1;
        @(negedge clk);

        exp_beats[0] = 64'hD1D1_D1D1_D1D1_D1D1;
        exp_beats[1] = 64'hD2D2_D2D2_D2D2_D2D2;
        exp_beats[2] = 64'hC3C3_C3C3_C3C3_C3C3;
        exp_beats[3] = 64'hC4C4_C4C4_C4C4_C4C4;
        applyStimulus(0, 1'b1, 1'b0, 32'hC0, exp_beats, -1, lat, nresp, got);
        checkOutput("postreset latency", 64'(lat), 64'd3);
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("postreset rdata[%0d]", b), got[b], exp_beats[b]);
        end
        checkOutput("postreset rd_bursts", 64'(rdc_a[0]), 64'd1);
        checkOutput("postreset wr_bursts", 64'(wrc_a[0]), 64'd0);
        checkOutput("postreset error",     64'(error_a[0]), 64'd0);

        // Latency sweep with back-to-back bursts on the LATENCY 1 and 5 copies.
        rstn_a[0] = 1'b0;
        rstn_a[1] = 1'b1;
        @(negedge clk);
        measureBackToBack(1, 1);
        rstn_a[1] = 1'b0;
        rstn_a[2] = 1'b1;
        @(negedge clk);
        measureBackToBack(2, 5);
        rstn_a[2] = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
